freelist: RTL and testbench

//  Physical-register free list for the 3-way R10K pipeline. Circular FIFO of free PR

---
 rtl/freelist_if.sv | 42 ++++
 rtl/freelist.sv | 118 +++++++++++
 tb/tb_freelist.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/freelist_if.sv
// Dispatch/retire handshake bundle for the physical-register free list.
//   dispatch_req       contiguous-prefix PR requests from dispatch
//   alloc_valid        per-way grant (combinational)
//   alloc_idx          per-way PR index, way i at [i*PR_BITS +: PR_BITS]
//   free_cnt           registered count of free PRs
//   retire_valid       contiguous-prefix Told returns from retire
//   retire_told_idx    per-way Told index, way i at [i*PR_BITS +: PR_BITS]
//   br_recover_enable  branch recovery at retire this cycle
// master: pipeline side; slave: free list.
interface freelist_if #(
    parameter int unsigned WAYS     = 3,
    parameter int unsigned PR_BITS  = 6,
    parameter int unsigned CNT_BITS = 6
);
    logic [WAYS-1:0]         dispatch_req;
    logic [WAYS-1:0]         alloc_valid;
    logic [WAYS*PR_BITS-1:0] alloc_idx;
    logic [CNT_BITS-1:0]     free_cnt;
    logic [WAYS-1:0]         retire_valid;
    logic [WAYS*PR_BITS-1:0] retire_told_idx;
    logic                    br_recover_enable;

    modport master (
        output dispatch_req,
        output retire_valid,
        output retire_told_idx,
        output br_recover_enable,
        input  alloc_valid,
        input  alloc_idx,
        input  free_cnt
    );

    modport slave (
        input  dispatch_req,
        input  retire_valid,
        input  retire_told_idx,
        input  br_recover_enable,
        output alloc_valid,
        output alloc_idx,
        output free_cnt
    );
endinterface

// File: rtl/freelist.sv
// Physical-register free list: circular FIFO of free PR indices.
// Dispatch pops up to WAYS PRs per cycle, retire pushes up to WAYS Told
// indices per cycle. A retire-side head copy (rhead) restores the list to
// architectural state on branch recovery.
//   clock  posedge clock
//   reset  synchronous, active-low
//   fl     freelist_if.slave (dispatch grant/index, free count, retire returns,
//          recovery strobe)
module freelist #(
    parameter int unsigned WAYS       = 3,
    parameter int unsigned N_PHYS_REG = 64,
    parameter int unsigned N_ARCH_REG = 32,
    parameter int unsigned PR_BITS    = $clog2(N_PHYS_REG),
    parameter int unsigned DEPTH      = N_PHYS_REG - N_ARCH_REG
) (
    input logic       clock,
    input logic       reset,
    freelist_if.slave fl
);
    localparam int unsigned PTR_BITS = $clog2(DEPTH);
    localparam int unsigned CNT_BITS = PTR_BITS + 1;

    typedef logic [PTR_BITS-1:0] ptr_t;
    typedef logic [CNT_BITS-1:0] cnt_t;
    typedef logic [PR_BITS-1:0]  pr_t;

    pr_t  entry_q [DEPTH];
    pr_t  entry_d [DEPTH];
    ptr_t head_q, head_d;
    ptr_t tail_q, tail_d;
    ptr_t rhead_q, rhead_d;
    cnt_t count_q, count_d;

    logic [WAYS-1:0] grant;
    cnt_t            n_alloc;
    cnt_t            n_ret;

    // Grants and indices come straight from registered state: no bypass of
    // this cycle's retire returns.
    always_comb begin
        grant        = '0;
        fl.alloc_idx = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            grant[i] = fl.dispatch_req[i] && (cnt_t'(i) < count_q);
            fl.alloc_idx[i*PR_BITS +: PR_BITS] = entry_q[head_q + ptr_t'(i)];
        end
    end

    assign fl.alloc_valid = grant;
    assign fl.free_cnt    = count_q;

    always_comb begin
        n_alloc = '0;
        n_ret   = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            n_alloc = n_alloc + cnt_t'(grant[i]);
            n_ret   = n_ret + cnt_t'(fl.retire_valid[i]);
        end
    end

    always_comb begin
        entry_d = entry_q;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (fl.retire_valid[i]) begin
                entry_d[tail_q + ptr_t'(i)] = fl.retire_told_idx[i*PR_BITS +: PR_BITS];
            end
        end
        tail_d  = tail_q + ptr_t'(n_ret);
        rhead_d = rhead_q + ptr_t'(n_ret);
        // Recovery: tail and rhead always coincide, so snapping head to the
        // updated rhead makes every slot free again; grants this cycle are dropped.
        if (fl.br_recover_enable) begin
            head_d  = rhead_d;
            count_d = cnt_t'(DEPTH);
        end else begin
            head_d  = head_q + ptr_t'(n_alloc);
            count_d = count_q - n_alloc + n_ret;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                entry_q[k] <= pr_t'(N_ARCH_REG + k);
            end
            head_q  <= '0;
            tail_q  <= '0;
            rhead_q <= '0;
            count_q <= cnt_t'(DEPTH);
        end else begin
            entry_q <= entry_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            rhead_q <= rhead_d;
            count_q <= count_d;
        end
    end

    function automatic logic is_prefix(input logic [WAYS-1:0] m);
        logic [WAYS:0] x;
        x = {1'b0, m};
        return (x & (x + (WAYS+1)'(1))) == '0;
    endfunction

    logic [CNT_BITS:0] fill_next;
    assign fill_next = {1'b0, count_q} - {1'b0, n_alloc} + {1'b0, n_ret};

    a_req_prefix: assert property (@(posedge clock) disable iff (!reset)
        is_prefix(fl.dispatch_req));
    a_ret_prefix: assert property (@(posedge clock) disable iff (!reset)
        is_prefix(fl.retire_valid));
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
        fill_next <= (CNT_BITS+1)'(DEPTH));
    a_count_bound: assert property (@(posedge clock) disable iff (!reset)
        count_q <= cnt_t'(DEPTH));
    a_tail_rhead: assert property (@(posedge clock) disable iff (!reset)
        tail_q == rhead_q);
endmodule

// File: tb/tb_freelist.sv
// Directed bench for freelist: reset state, in-order allocation to empty,
// wrap-around refill, branch recovery, mid-stream reset and sustained
// 3-in/3-out traffic against a queue model.
module tb_freelist;
    localparam int WAYS     = 3;
    localparam int PR_BITS  = 6;
    localparam int CNT_BITS = 6;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    freelist_if #(.WAYS(WAYS), .PR_BITS(PR_BITS), .CNT_BITS(CNT_BITS)) fl_if ();

    freelist #(
        .WAYS(WAYS),
        .N_PHYS_REG(64),
        .N_ARCH_REG(32),
        .PR_BITS(PR_BITS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .fl(fl_if.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] way_idx(input int i);
        return 32'(fl_if.alloc_idx[i*PR_BITS +: PR_BITS]);
    endfunction

    function automatic logic [31:0] cnt();
        return 32'(fl_if.free_cnt);
    endfunction

    function automatic logic [31:0] vld();
        return 32'(fl_if.alloc_valid);
    endfunction

    // Apply one cycle of inputs away from the clock edge, then let comb settle.
    task automatic drive(input logic [2:0] req, input logic [2:0] rv,
                         input int t0, input int t1, input int t2, input logic rec);
        @(negedge clock);
        fl_if.dispatch_req      = req;
        fl_if.retire_valid      = rv;
        fl_if.retire_told_idx   = {6'(t2), 6'(t1), 6'(t0)};
        fl_if.br_recover_enable = rec;
        #1;
    endtask

    // One posedge with reset low; busy drives full traffic to show reset wins.
    task automatic do_reset(input logic busy);
        @(negedge clock);
        reset                   = 1'b0;
        fl_if.dispatch_req      = busy ? 3'b111 : 3'b000;
        fl_if.retire_valid      = busy ? 3'b111 : 3'b000;
        fl_if.retire_told_idx   = {6'd9, 6'd8, 6'd7};
        fl_if.br_recover_enable = busy;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    int q[$];

    initial begin
        fl_if.dispatch_req      = '0;
        fl_if.retire_valid      = '0;
        fl_if.retire_told_idx   = '0;
        fl_if.br_recover_enable = 1'b0;

        // Reset then drain the list three at a time: 32..61 in order.
        do_reset(1'b0);
        for (int c = 0; c < 10; c++) begin
            drive(3'b111, 3'b000, 0, 0, 0, 1'b0);
            check_eq("drain_cnt", cnt(), 32 - 3*c);
            check_eq("drain_vld", vld(), 7);
            for (int i = 0; i < 3; i++) check_eq("drain_idx", way_idx(i), 32 + 3*c + i);
        end
        // Two left: partial grant.
        drive(3'b111, 3'b000, 0, 0, 0, 1'b0);
        check_eq("partial_cnt", cnt(), 2);
        check_eq("partial_vld", vld(), 3);
        check_eq("partial_idx0", way_idx(0), 62);
        check_eq("partial_idx1", way_idx(1), 63);
        // Empty: no grant while retiring {5,6,7}.
        drive(3'b111, 3'b111, 5, 6, 7, 1'b0);
        check_eq("empty_cnt", cnt(), 0);
        check_eq("empty_vld", vld(), 0);
        // Returns visible next cycle, wrapped through index 0.
        drive(3'b111, 3'b000, 0, 0, 0, 1'b0);
        check_eq("refill_cnt", cnt(), 3);
        check_eq("refill_vld", vld(), 7);
        check_eq("refill_idx0", way_idx(0), 5);
        check_eq("refill_idx1", way_idx(1), 6);
        check_eq("refill_idx2", way_idx(2), 7);
        drive(3'b000, 3'b000, 0, 0, 0, 1'b0);
        check_eq("reempty_cnt", cnt(), 0);

        // Recovery: allocate 6, then retire {1,2} with recovery.
        do_reset(1'b0);
        drive(3'b111, 3'b000, 0, 0, 0, 1'b0);
        drive(3'b111, 3'b000, 0, 0, 0, 1'b0);
        check_eq("pre_rec_idx2", way_idx(2), 37);
        drive(3'b111, 3'b011, 1, 2, 0, 1'b1);
        check_eq("rec_cnt", cnt(), 26);
        check_eq("rec_idx0", way_idx(0), 38);
        drive(3'b001, 3'b000, 0, 0, 0, 1'b0);
        check_eq("post_rec_cnt", cnt(), 32);
        check_eq("post_rec_idx0", way_idx(0), 34);
        check_eq("post_rec_idx1", way_idx(1), 35);
        check_eq("post_rec_idx2", way_idx(2), 36);
        check_eq("single_req_vld", vld(), 1);
        // Mixed traffic.
        drive(3'b111, 3'b001, 9, 0, 0, 1'b0);
        check_eq("mix1_cnt", cnt(), 31);
        check_eq("mix1_idx0", way_idx(0), 35);
        drive(3'b011, 3'b111, 10, 11, 12, 1'b0);
        check_eq("mix2_cnt", cnt(), 29);
        check_eq("mix2_idx0", way_idx(0), 38);
        drive(3'b000, 3'b000, 0, 0, 0, 1'b0);
        check_eq("mix3_cnt", cnt(), 30);

        // Mid-stream reset with traffic asserted.
        do_reset(1'b1);
        drive(3'b111, 3'b000, 0, 0, 0, 1'b0);
        check_eq("rst_cnt", cnt(), 32);
        check_eq("rst_vld", vld(), 7);
        check_eq("rst_idx0", way_idx(0), 32);
        check_eq("rst_idx1", way_idx(1), 33);
        check_eq("rst_idx2", way_idx(2), 34);

        // Sustained 3-in/3-out against a FIFO model.
        do_reset(1'b0);
        q.delete();
        for (int k = 0; k < 32; k++) q.push_back(32 + k);
        for (int c = 0; c < 100; c++) begin
            int t[3];
            for (int i = 0; i < 3; i++) t[i] = (c*3 + i) % 32;
            drive(3'b111, 3'b111, t[0], t[1], t[2], 1'b0);
            check_eq("steady_cnt", cnt(), q.size());
            check_eq("steady_vld", vld(), 7);
            for (int i = 0; i < 3; i++) check_eq("steady_idx", way_idx(i), q[i]);
            for (int i = 0; i < 3; i++) void'(q.pop_front());
            for (int i = 0; i < 3; i++) q.push_back(t[i]);
        end
        drive(3'b000, 3'b000, 0, 0, 0, 1'b0);
        check_eq("steady_end_cnt", cnt(), 32);
        check_eq("steady_end_idx0", way_idx(0), q[0]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
